// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
// Shared types and constants for the UART TX arbiter slice.
//   arb_state_e : arbiter FSM states (IDLE, GRANT)
//   BYTE_W      : width of one UART byte
//   CNT_W       : width of the per-grant byte and idle counters
//   wrap_add    : modulo-n addition used for round-robin index arithmetic
package uart_arb_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Adds off to base and wraps into 0..n-1. Both operands are already below n,
  // so a single conditional subtract is enough and non-power-of-two n never
  // produces an out-of-range index.
  function automatic int wrap_add(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick
// Combinational round-robin picker: finds the first set candidate bit at or
// after rr_ptr, wrapping modulo N_REQ.
//   candidates : in  N_REQ  requesters eligible this cycle
//   rr_ptr     : in  IDX_W  highest-priority index
//   found      : out 1      at least one candidate is set
//   index      : out IDX_W  chosen requester (0 when none found)
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] candidates,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  // Scan from the lowest-priority offset up to offset 0 so the last hit
  // written is the one closest to rr_ptr.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (candidates[IDX_W'(wrap_add(int'(rr_ptr), k, N_REQ))]) begin
        found = 1'b1;
        index = IDX_W'(wrap_add(int'(rr_ptr), k, N_REQ));
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter sharing one UART byte serializer between N_REQ byte
// streams, with optional packet locking and a one-entry output buffer.
//   clk, rst_n  : clock, synchronous active-low reset
//   req_valid   : in  N_REQ    per-requester byte valid
//   req_data    : in  8*N_REQ  requester i byte at [8i+7:8i]
//   req_last    : in  N_REQ    final byte of packet
//   req_ready   : out N_REQ    accept, one-hot or zero
//   en_mask     : in  N_REQ    requester enable
//   tx_valid/tx_data/tx_ready : byte handshake towards the serializer
//   grant_id    : out IDX_W    current/last grantee
//   busy        : out 1        GRANT state or byte buffered
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int N_REQ        = 4,
  parameter  int LOCK_PACKETS = 1,
  parameter  int MAX_PKT      = 64,
  parameter  int IDLE_TIMEOUT = 16,
  localparam int IDX_W        = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        en_mask,
  output logic                    tx_valid,
  output logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_ready,
  output logic [IDX_W-1:0]        grant_id,
  output logic                    busy
);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  grant_id_q, grant_id_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic              tx_valid_q, tx_valid_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;

  logic [BYTE_W-1:0] req_bytes [N_REQ];
  logic [N_REQ-1:0]  candidates;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_index;
  logic              g_valid, g_en, g_last, g_ready, xfer, release_now;
  logic [CNT_W-1:0]  byte_cnt_inc, idle_cnt_inc;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign req_bytes[i] = req_data[BYTE_W*i +: BYTE_W];
  end

  assign candidates = req_valid & en_mask;

  uart_rr_pick #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .candidates(candidates),
    .rr_ptr    (rr_ptr_q),
    .found     (pick_found),
    .index     (pick_index)
  );

  // req_ready depends only on registered state, en_mask and tx_ready, never
  // on req_valid, so requesters can safely wait for ready before valid.
  assign g_valid      = req_valid[grant_id_q];
  assign g_en         = en_mask[grant_id_q];
  assign g_last       = req_last[grant_id_q];
  assign g_ready      = (state_q == GRANT) && g_en && (!tx_valid_q || tx_ready);
  assign xfer         = g_ready && g_valid;
  assign byte_cnt_inc = byte_cnt_q + CNT_W'(1);
  assign idle_cnt_inc = idle_cnt_q + CNT_W'(1);

  always_comb begin
    req_ready = '0;
    if (g_ready) req_ready[grant_id_q] = 1'b1;
  end

  // Arbiter next state. All release causes are OR-ed into one flag so that
  // coincident causes still advance the round-robin pointer exactly once.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    release_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_index;
          byte_cnt_d = '0;
          idle_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_inc;
          idle_cnt_d = '0;
        end else if (!g_valid) begin
          idle_cnt_d = idle_cnt_inc;
        end
        if (xfer && (g_last || (LOCK_PACKETS == 0) ||
                     (byte_cnt_inc == CNT_W'(MAX_PKT)))) release_now = 1'b1;
        if (!g_valid && (idle_cnt_inc == CNT_W'(IDLE_TIMEOUT))) release_now = 1'b1;
        if (!g_en) release_now = 1'b1;
        if (release_now) begin
          state_d  = IDLE;
          rr_ptr_d = IDX_W'(wrap_add(int'(grant_id_q), 1, N_REQ));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output buffer runs independently of the FSM: a drain and a fresh load may
  // coincide, and a byte loaded on the release transfer still drains later.
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (tx_valid_q && tx_ready) tx_valid_d = 1'b0;
    if (xfer) begin
      tx_valid_d = 1'b1;
      tx_data_d  = req_bytes[grant_id_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q == GRANT) || tx_valid_q;

endmodule
